affinex_point_fifo: RTL
=======================

Name: affinex_point_fifo

Overview:
Input point buffer that sits directly upstream of the affine transform engine in the TinyQV affinex peripheral. The CPU writes X and Y coordinates separately; this block pairs them into one point and queues the point. The engine pops points through a first-word-fall-through (FWFT) read port. The block reports occupancy and latches sticky error flags for the status register.

Parameters:
DEPTH, 8, number of point entries; must be a power of 2, minimum 2
WIDTH, 16, bits per coordinate (signed Q8.8 in the engine)

Ports:
clk  input  1  project clock (64 MHz nominal)
rst_n  input  1  reset; synchronous, active-low
clear  input  1  synchronous flush: empties FIFO, drops staged X, clears sticky flags
wr_x_en  input  1  one-cycle strobe; stage wr_data as X
wr_y_en  input  1  one-cycle strobe; pair wr_data as Y with staged X and push
wr_data  input  WIDTH  coordinate from CPU data_in[15:0]
rd_en  input  1  engine pop strobe
rd_x  output  WIDTH  head-entry X (FWFT)
rd_y  output  WIDTH  head-entry Y (FWFT)
empty  output  1  no entries
full  output  1  DEPTH entries
count  output  $clog2(DEPTH)+1  current occupancy
x_pending  output  1  X staged, awaiting Y
overflow  output  1  sticky: push attempted while full
underflow  output  1  sticky: pop attempted while empty
pair_err  output  1  sticky: Y written with no staged X, or X written while X already pending

Behaviour:
- All state updates on posedge clk. When rst_n=0 at a clock edge: pointers=0, count=0, empty=1, full=0, x_pending=0, staged X=0, all sticky flags=0, rd_x=rd_y=0.
- Storage: DEPTH x 2*WIDTH register array. Write and read pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count tracks occupancy separately.
- FWFT read: rd_x/rd_y are driven combinationally from the entry at the read pointer. They are valid whenever empty=0. When empty=1, both are driven to 0.
- wr_x_en: staged X <= wr_data; x_pending <= 1. If x_pending was already 1, the new value overwrites the old one and pair_err is set.
- wr_y_en: forms the point {staged X, wr_data} and pushes it.
  - If x_pending=0, the push still happens using the last staged X, and pair_err is set.
  - x_pending <= 0 in both cases.
- Push when full: the point is dropped, overflow is set, and pointers and count are unchanged. x_pending is still cleared.
- Pop (rd_en) when empty: ignored; underflow is set.
- Simultaneous push and pop:
  - Not empty and not full: both occur; count unchanged.
  - Full: the pop occurs and the push is dropped (overflow set), because full is evaluated before the pop.
  - Empty: the push occurs and the pop is ignored (underflow set). There is no bypass path.
- wr_x_en and wr_y_en in the same cycle: Y is paired with the previously staged X, then the new X is staged; x_pending ends at 1. pair_err follows the Y rule only.
- Latency: a pushed point appears on rd_x/rd_y, and empty falls, one cycle after the wr_y_en edge.
- full = (count==DEPTH); empty = (count==0).
- clear takes priority over every strobe in the same cycle and produces the reset state, except that stored array contents are not zeroed.
- Sticky flags are cleared only by reset or clear.
- Reset or clear during a burst: all in-flight staging and queued points are lost, and there is no partial state.

Optional Feature:
AFFINEX_FIFO_THRESH_EN
- Defined: adds input thresh [$clog2(DEPTH):0] and output thresh_irq.
  - thresh_irq is a registered level: 1 when count >= thresh and thresh != 0.
  - It updates the cycle after count changes and resets to 0.
  - The peripheral routes it to user_interrupt.
- Undefined: neither port exists, no threshold logic is built, and user_interrupt remains 0.

Test Plan:
1. Reset, then write X=0x0100, Y=0xFF00 -> next cycle: empty=0, count=1, rd_x=0x0100, rd_y=0xFF00, x_pending=0, all flags=0.
2. Push 8 points (X=i, Y=i+0x10 for i=0..7, DEPTH=8) -> full=1, count=8. A 9th pair sets overflow=1 with count still 8. Pop 8 times -> values return in order 0..7, then empty=1.
3. Pop on empty -> underflow=1, count=0. Then push+pop in the same cycle while empty -> count=1, underflow stays 1.
4. Fill to 7, then alternate push+pop for 20 cycles -> count stays 7, pointers wrap, output order preserved, no flags set.
5. Write Y=0x0005 with no pending X after reset -> pair_err=1, entry {0x0000, 0x0005} queued. Write X twice -> pair_err stays 1, second X used. Assert clear -> count=0, all flags=0, x_pending=0.
6. (AFFINEX_FIFO_THRESH_EN) thresh=3: push 3 points -> thresh_irq=1 one cycle after the third push. Pop 1 -> thresh_irq=0 next cycle. thresh=0 -> thresh_irq never asserts.

Source files
------------

// File: rtl/affinex_point_fifo.sv
// affinex_point_fifo: pairs CPU X/Y coordinate writes into points and queues them for the affine engine (FWFT read).
// Define AFFINEX_FIFO_THRESH_EN to build the occupancy threshold interrupt (thresh / thresh_irq).
module affinex_point_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    wr_x_en,
    input  logic                    wr_y_en,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    rd_en,
`ifdef AFFINEX_FIFO_THRESH_EN
    input  logic [$clog2(DEPTH):0]  thresh,
    output logic                    thresh_irq,
`endif
    output logic [WIDTH-1:0]        rd_x,
    output logic [WIDTH-1:0]        rd_y,
    output logic                    empty,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    x_pending,
    output logic                    overflow,
    output logic                    underflow,
    output logic                    pair_err
);
    localparam int AW = $clog2(DEPTH);
    logic [2*WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]      wp, rp;
    logic [WIDTH-1:0]   x_stage;
    logic               push, pop, flush;
    assign flush = !rst_n || clear;
    assign empty = count == '0;
    assign full  = count == (AW+1)'(DEPTH);
    // full/empty are judged on the pre-edge count, so a full FIFO pops but drops the push
    assign push  = wr_y_en && !full;
    assign pop   = rd_en && !empty;
    assign rd_x  = empty ? '0 : mem[rp][2*WIDTH-1:WIDTH];
    assign rd_y  = empty ? '0 : mem[rp][WIDTH-1:0];
    always_ff @(posedge clk) begin
        if (!flush && push) mem[wp] <= {x_stage, wr_data};
    end
    always_ff @(posedge clk) begin
        if (flush) begin
            wp        <= '0;
            rp        <= '0;
            count     <= '0;
            x_stage   <= '0;
            x_pending <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            pair_err  <= 1'b0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop) rp <= rp + AW'(1);
            count     <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (wr_x_en) x_stage <= wr_data;
            x_pending <= wr_x_en || (x_pending && !wr_y_en);
            overflow  <= overflow || (wr_y_en && full);
            underflow <= underflow || (rd_en && empty);
            // a same-cycle X+Y is judged by the Y rule alone
            pair_err  <= pair_err || (wr_y_en && !x_pending) || (wr_x_en && !wr_y_en && x_pending);
        end
    end
`ifdef AFFINEX_FIFO_THRESH_EN
    always_ff @(posedge clk) begin
        if (flush) thresh_irq <= 1'b0;
        else thresh_irq <= (thresh != '0) && (count >= thresh);
    end
`endif
endmodule
